stack_seq: RTL and testbench
============================

Name: stack_seq

Overview:
- Multi-cycle stack-access sequencer sitting directly upstream of the core I/O register file.
- Accepts PUSH/POP/CALL/RET commands from the instruction decoder.
- Drives the register file's SP count-enable and direction (sp_en, sp_ndown_up) and reads back the live SP.
- Issues one data-RAM byte access per active cycle at the SP-derived address and assembles return PCs for RET.

Parameters:
- pc22b, 0: 0 = 16-bit PC, 2-byte CALL/RET frames; 1 = 22-bit PC, 3-byte frames.

Ports:
- cp2  input  1  clock.
- ireset  input  1  reset, asynchronous, active-low.
- cp2en  input  1  clock enable; when low the block freezes.
- cmd_valid  input  1  command request.
- cmd  input  2  0=PUSH, 1=POP, 2=CALL, 3=RET.
- busy  output  1  sequence in progress; new commands ignored.
- done  output  1  one-cycle completion pulse.
- push_data  input  8  PUSH operand, sampled at accept.
- pc_in  input  22  return address for CALL, sampled at accept; bits 21:16 ignored when pc22b=0.
- spl_in  input  8  current SPL from register file.
- sph_in  input  8  current SPH from register file.
- sp_en  output  1  SP count enable to register file.
- sp_ndown_up  output  1  SP direction to register file: 0 = decrement, 1 = increment.
- ram_adr  output  16  data-RAM byte address.
- ram_we  output  1  RAM write strobe.
- ram_re  output  1  RAM read strobe.
- ram_dout  output  8  RAM write data.
- ram_din  input  8  RAM read data, valid the active cycle after ram_re.
- pop_data  output  8  last POP result.
- ret_pc  output  22  last RET result; upper bits zero when pc22b=0.

Behaviour:
- Reset and idle levels:
  - Reset (async, ireset=0): state IDLE; every output 0.
  - Reset mid-sequence aborts it; no done pulse.
  - In IDLE: ram_adr=0, strobes 0.
- Clock enable:
  - All state changes occur on cp2 rising edges with cp2en=1.
  - With cp2en=0: sp_en, ram_we and ram_re are forced 0, and state/counters/captures hold.
- Accept: cmd_valid=1 and busy=0 at an enabled edge. Latch cmd, push_data, pc_in; set byte counter.
- N = 2 + pc22b. busy is high from the cycle after accept through the done cycle inclusive.
- SP = {sph_in,spl_in}, read live each cycle. The register file updates SP one edge after sp_en, so back-to-back accesses each see the updated SP.
- State WR (PUSH: 1 byte; CALL: N bytes), one byte per active cycle:
  - ram_we=1, ram_adr=SP, sp_en=1, sp_ndown_up=0 (post-decrement).
  - CALL byte order: PC[7:0], PC[15:8], then {2'b00,PC[21:16]} if pc22b.
  - done asserted in the last WR cycle, then IDLE.
- State RD (POP: 1 byte; RET: N bytes), one byte per active cycle:
  - ram_re=1, ram_adr=SP+1 (mod 2^16), sp_en=1, sp_ndown_up=1 (pre-increment).
  - RET read order is highest byte first, PC[7:0] last.
- State CAP: the active cycle after each read captures ram_din into pop_data or the correct ret_pc byte.
  - Captures overlap subsequent reads.
  - One final CAP cycle follows the last read, with no strobes and sp_en=0.
  - done is asserted in the final CAP cycle; pop_data/ret_pc are valid from the following cycle and hold until the next POP/RET completes.
- Latencies from accept edge to done: PUSH 1, CALL N, POP 2, RET N+1 active cycles.
- Wrap-around:
  - SP=0x0000 push writes 0x0000, and SP becomes 0xFFFF.
  - SP=0xFFFF pop reads 0x0000.
  - No overflow detection.
- cmd_valid while busy is ignored, not queued. Back-to-back: a new command may be accepted at the edge ending the done cycle.
- RET upper byte with pc22b=1: only ram_din[5:0] is used; bits 7:6 are discarded.
- External SP writes (iowe) during a sequence are not blocked; the sequencer uses whatever SP the register file presents.

Test Plan:
- PUSH 0xA5, SP=0x10FF:
  - Required: one cycle with ram_we, adr 0x10FF, dout 0xA5, sp_en=1, sp_ndown_up=0, done.
  - With register-file model: SP=0x10FE afterwards.
- CALL pc_in=0x001234, pc22b=0, SP=0x0200:
  - Required: writes 0x34 @0x0200, then 0x12 @0x01FF.
  - done on cycle 2; SP=0x01FE.
- RET after the above, pc22b=0:
  - Required: reads @0x01FF then @0x0200; ret_pc=0x001234.
  - done on cycle 3; SP=0x0200.
- pc22b=1 CALL 0x3ABCDE then RET, SP=0x0300:
  - Required: writes 0xDE, 0xBC, 0x3A at 0x0300/0x02FF/0x02FE.
  - RET returns ret_pc=0x3ABCDE.
- POP with SP=0xFFFF, RAM[0x0000]=0x5A:
  - Required: ram_adr=0x0000; pop_data=0x5A; SP=0x0000.
- Stall/abort:
  - cp2en=0 for 3 cycles mid-CALL: strobes low, sequence resumes with identical byte order.
  - ireset pulse mid-RET: all outputs 0, no done, next command accepted normally.

Source files
------------

// File: rtl/stack_seq.sv
`default_nettype none
// ============================================================================
// Module      : stack_seq
// Description : Multi-cycle stack-access sequencer for PUSH/POP/CALL/RET.
//               Drives SP count-enable/direction towards the I/O register
//               file and issues one data-RAM byte access per active cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_seq #(
    parameter int pc22b = 0
) (
    input  logic        cp2,
    input  logic        ireset,
    input  logic        cp2en,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd,
    output logic        busy,
    output logic        done,
    input  logic [7:0]  push_data,
    input  logic [21:0] pc_in,
    input  logic [7:0]  spl_in,
    input  logic [7:0]  sph_in,
    output logic        sp_en,
    output logic        sp_ndown_up,
    output logic [15:0] ram_adr,
    output logic        ram_we,
    output logic        ram_re,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din,
    output logic [7:0]  pop_data,
    output logic [21:0] ret_pc
);

    localparam logic [1:0] CMD_PUSH = 2'd0;
    localparam logic [1:0] CMD_POP  = 2'd1;
    localparam logic [1:0] CMD_CALL = 2'd2;
    localparam logic [1:0] CMD_RET  = 2'd3;

    // Index of the last byte of a CALL/RET frame (frame is 2 or 3 bytes)
    localparam logic [1:0] LAST_IDX = (pc22b != 0) ? 2'd2 : 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_CAP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [1:0]  cnt_q, cnt_d;          // byte index of the current access
    logic [1:0]  cap_idx_q, cap_idx_d;  // byte index the pending read targets
    logic        cap_vld_q, cap_vld_d;  // a read was issued last active cycle
    logic [7:0]  wdata_q, wdata_d;
    logic [21:0] pc_q, pc_d;
    logic [21:0] asm_q, asm_d;          // RET bytes assembled before commit
    logic [7:0]  pop_data_q, pop_data_d;
    logic [21:0] ret_pc_q, ret_pc_d;

    logic [15:0] sp;
    logic [7:0]  frame_byte;
    logic        done_w;
    logic        sp_en_w;
    logic        dir_w;
    logic        we_w;
    logic        re_w;
    logic [15:0] adr_w;
    logic [7:0]  dout_w;

    assign sp = {sph_in, spl_in};

    // Select the byte written in the current WR cycle (CALL frame: low byte first)
    always_comb begin
        frame_byte = wdata_q;
        if (cmd_q == CMD_CALL) begin
            case (cnt_q)
                2'd0:    frame_byte = pc_q[7:0];
                2'd1:    frame_byte = pc_q[15:8];
                default: frame_byte = {2'b00, pc_q[21:16]};
            endcase
        end
    end

    // Sequencing: next state, access strobes, read captures and command accept
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        cnt_d      = cnt_q;
        cap_idx_d  = cap_idx_q;
        cap_vld_d  = 1'b0;
        wdata_d    = wdata_q;
        pc_d       = pc_q;
        asm_d      = asm_q;
        pop_data_d = pop_data_q;
        ret_pc_d   = ret_pc_q;
        done_w     = 1'b0;
        sp_en_w    = 1'b0;
        dir_w      = 1'b0;
        we_w       = 1'b0;
        re_w       = 1'b0;
        adr_w      = 16'h0000;
        dout_w     = 8'h00;

        // Read data of the previous active cycle lands now; overlaps later reads
        if (cap_vld_q) begin
            if (cmd_q == CMD_POP) begin
                pop_data_d = ram_din;
            end else begin
                case (cap_idx_q)
                    2'd0:    asm_d[7:0]   = ram_din;
                    2'd1:    asm_d[15:8]  = ram_din;
                    default: asm_d[21:16] = ram_din[5:0];
                endcase
            end
        end

        case (state_q)
            ST_WR: begin
                we_w    = 1'b1;
                adr_w   = sp;
                dout_w  = frame_byte;
                sp_en_w = 1'b1;
                dir_w   = 1'b0;
                if ((cmd_q == CMD_PUSH) || (cnt_q == LAST_IDX)) begin
                    done_w  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_RD: begin
                re_w      = 1'b1;
                adr_w     = sp + 16'd1;
                sp_en_w   = 1'b1;
                dir_w     = 1'b1;
                cap_vld_d = 1'b1;
                cap_idx_d = cnt_q;
                if (cnt_q == 2'd0) begin
                    state_d = ST_CAP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_CAP: begin
                done_w  = 1'b1;
                state_d = ST_IDLE;
                if (cmd_q == CMD_RET) begin
                    ret_pc_d = asm_d;
                end
            end
            default: ;
        endcase

        // Accept in IDLE, or back-to-back at the edge ending a done cycle
        if (cmd_valid && ((state_q == ST_IDLE) || done_w)) begin
            cmd_d   = cmd;
            wdata_d = push_data;
            pc_d    = (pc22b != 0) ? pc_in : {6'b000000, pc_in[15:0]};
            asm_d   = 22'h000000;
            cnt_d   = (cmd == CMD_RET) ? LAST_IDX : 2'd0;
            state_d = ((cmd == CMD_PUSH) || (cmd == CMD_CALL)) ? ST_WR : ST_RD;
        end
    end

    // State and capture registers; everything holds while cp2en is low
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            state_q    <= ST_IDLE;
            cmd_q      <= 2'd0;
            cnt_q      <= 2'd0;
            cap_idx_q  <= 2'd0;
            cap_vld_q  <= 1'b0;
            wdata_q    <= 8'h00;
            pc_q       <= 22'h000000;
            asm_q      <= 22'h000000;
            pop_data_q <= 8'h00;
            ret_pc_q   <= 22'h000000;
        end else if (cp2en) begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            cnt_q      <= cnt_d;
            cap_idx_q  <= cap_idx_d;
            cap_vld_q  <= cap_vld_d;
            wdata_q    <= wdata_d;
            pc_q       <= pc_d;
            asm_q      <= asm_d;
            pop_data_q <= pop_data_d;
            ret_pc_q   <= ret_pc_d;
        end
    end

    // Strobes and the completion pulse only fire on enabled cycles
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_w & cp2en;
    assign sp_en       = sp_en_w & cp2en;
    assign ram_we      = we_w & cp2en;
    assign ram_re      = re_w & cp2en;
    assign sp_ndown_up = dir_w;
    assign ram_adr     = adr_w;
    assign ram_dout    = dout_w;
    assign pop_data    = pop_data_q;
    assign ret_pc      = ret_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_seq
// Description : Directed self-checking bench for stack_seq, with a small
//               register-file SP model and a byte RAM model. Two DUTs cover
//               the 16-bit and 22-bit PC variants; sel picks which one the
//               shared models serve.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_seq;

    localparam logic [1:0] CMD_PUSH = 2'd0;
    localparam logic [1:0] CMD_POP  = 2'd1;
    localparam logic [1:0] CMD_CALL = 2'd2;
    localparam logic [1:0] CMD_RET  = 2'd3;

    logic        cp2       = 1'b0;
    logic        ireset    = 1'b0;
    logic        cp2en     = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd       = 2'd0;
    logic [7:0]  push_data = 8'h00;
    logic [21:0] pc_in     = 22'h0;
    logic        sel       = 1'b0;

    logic [15:0] sp_m      = 16'h0000;
    logic [7:0]  ram_din_m = 8'h00;
    logic [7:0]  mem [0:65535];
    logic        sp_ld     = 1'b0;
    logic [15:0] sp_ld_val = 16'h0000;
    logic        mem_ld    = 1'b0;
    logic [15:0] mem_ld_adr = 16'h0000;
    logic [7:0]  mem_ld_val = 8'h00;

    int total = 0;
    int bad   = 0;

    logic        busy0, done0, sp_en0, dir0, we0, re0;
    logic [15:0] adr0;
    logic [7:0]  dout0, pop0;
    logic [21:0] ret0;
    logic        busy1, done1, sp_en1, dir1, we1, re1;
    logic [15:0] adr1;
    logic [7:0]  dout1, pop1;
    logic [21:0] ret1;

    logic        m_busy, m_done, m_sp_en, m_dir, m_we, m_re;
    logic [15:0] m_adr;
    logic [7:0]  m_dout, m_pop;
    logic [21:0] m_ret;
    logic        cv0, cv1;

    assign cv0     = cmd_valid & ~sel;
    assign cv1     = cmd_valid & sel;
    assign m_busy  = sel ? busy1  : busy0;
    assign m_done  = sel ? done1  : done0;
    assign m_sp_en = sel ? sp_en1 : sp_en0;
    assign m_dir   = sel ? dir1   : dir0;
    assign m_we    = sel ? we1    : we0;
    assign m_re    = sel ? re1    : re0;
    assign m_adr   = sel ? adr1   : adr0;
    assign m_dout  = sel ? dout1  : dout0;
    assign m_pop   = sel ? pop1   : pop0;
    assign m_ret   = sel ? ret1   : ret0;

    stack_seq #(.pc22b(0)) u_dut0 (
        .cp2(cp2), .ireset(ireset), .cp2en(cp2en), .cmd_valid(cv0), .cmd(cmd),
        .busy(busy0), .done(done0), .push_data(push_data), .pc_in(pc_in),
        .spl_in(sp_m[7:0]), .sph_in(sp_m[15:8]), .sp_en(sp_en0), .sp_ndown_up(dir0),
        .ram_adr(adr0), .ram_we(we0), .ram_re(re0), .ram_dout(dout0),
        .ram_din(ram_din_m), .pop_data(pop0), .ret_pc(ret0)
    );

    stack_seq #(.pc22b(1)) u_dut1 (
        .cp2(cp2), .ireset(ireset), .cp2en(cp2en), .cmd_valid(cv1), .cmd(cmd),
        .busy(busy1), .done(done1), .push_data(push_data), .pc_in(pc_in),
        .spl_in(sp_m[7:0]), .sph_in(sp_m[15:8]), .sp_en(sp_en1), .sp_ndown_up(dir1),
        .ram_adr(adr1), .ram_we(we1), .ram_re(re1), .ram_dout(dout1),
        .ram_din(ram_din_m), .pop_data(pop1), .ret_pc(ret1)
    );

    always #5 cp2 = ~cp2;

    // Register-file SP and data RAM models
    always @(posedge cp2) begin
        if (sp_ld)        sp_m <= sp_ld_val;
        else if (m_sp_en) sp_m <= m_dir ? sp_m + 16'd1 : sp_m - 16'd1;
        if (mem_ld)       mem[mem_ld_adr] <= mem_ld_val;
        else if (m_we)    mem[m_adr] <= m_dout;
        if (m_re)         ram_din_m <= mem[m_adr];
    end

    task automatic step();
        @(posedge cp2);
        #2;
    endtask

    task automatic set_sp(input logic [15:0] v);
        sp_ld = 1'b1; sp_ld_val = v;
        step();
        sp_ld = 1'b0;
    endtask

    task automatic set_mem(input logic [15:0] a, input logic [7:0] v);
        mem_ld = 1'b1; mem_ld_adr = a; mem_ld_val = v;
        step();
        mem_ld = 1'b0;
    endtask

    task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic [21:0] p);
        cmd_valid = 1'b1; cmd = c; push_data = d; pc_in = p;
        step();
        cmd_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        ireset = 1'b0; cmd_valid = 1'b1; cmd = CMD_CALL;
        step(); step();
        total++;
        if ({busy0, done0, sp_en0, dir0, we0, re0, adr0, dout0, pop0, ret0} !== 60'h0) begin
            bad++;
            $display("FAIL reset_dut0 outputs=%h required=0", {busy0, done0, sp_en0, dir0, we0, re0, adr0, dout0, pop0, ret0});
        end
        total++;
        if ({busy1, done1, sp_en1, dir1, we1, re1, adr1, dout1, pop1, ret1} !== 60'h0) begin
            bad++;
            $display("FAIL reset_dut1 outputs=%h required=0", {busy1, done1, sp_en1, dir1, we1, re1, adr1, dout1, pop1, ret1});
        end
        cmd_valid = 1'b0;
        ireset = 1'b1;
        step();
        total++;
        if ({busy0, busy1} !== 2'b00) begin
            bad++;
            $display("FAIL reset_idle busy=%b required=00", {busy0, busy1});
        end
    endtask

    task automatic test_push();
        sel = 1'b0;
        set_sp(16'h10FF);
        issue(CMD_PUSH, 8'hA5, 22'h0);
        total++;
        if ({m_we, m_re, m_sp_en, m_dir, m_busy, m_done} !== 6'b101011 || m_adr !== 16'h10FF || m_dout !== 8'hA5) begin
            bad++;
            $display("FAIL push ctl=%b adr=%h dout=%h required ctl=101011 adr=10ff dout=a5", {m_we, m_re, m_sp_en, m_dir, m_busy, m_done}, m_adr, m_dout);
        end
        step();
        total++;
        if ({m_we, m_re, m_sp_en, m_busy, m_done} !== 5'b0 || m_adr !== 16'h0 || sp_m !== 16'h10FE || mem[16'h10FF] !== 8'hA5) begin
            bad++;
            $display("FAIL push_after ctl=%b adr=%h sp=%h mem=%h required ctl=0 adr=0 sp=10fe mem=a5", {m_we, m_re, m_sp_en, m_busy, m_done}, m_adr, sp_m, mem[16'h10FF]);
        end
        // Wrap: push at SP=0000 writes 0000, SP becomes FFFF
        set_sp(16'h0000);
        issue(CMD_PUSH, 8'h77, 22'h0);
        total++;
        if (m_we !== 1'b1 || m_adr !== 16'h0000 || m_dout !== 8'h77 || m_done !== 1'b1) begin
            bad++;
            $display("FAIL push_wrap we=%b adr=%h dout=%h done=%b required 1/0000/77/1", m_we, m_adr, m_dout, m_done);
        end
        step();
        total++;
        if (sp_m !== 16'hFFFF) begin
            bad++;
            $display("FAIL push_wrap_sp sp=%h required=ffff", sp_m);
        end
    endtask

    task automatic test_call16();
        logic [15:0] ea [2];
        logic [7:0]  ed [2];
        ea = '{16'h0200, 16'h01FF};
        ed = '{8'h34, 8'h12};
        sel = 1'b0;
        set_sp(16'h0200);
        issue(CMD_CALL, 8'h00, 22'h001234);
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({m_we, m_re, m_sp_en, m_dir, m_busy} !== 5'b10101 || m_done !== (i == 1) || m_adr !== ea[i] || m_dout !== ed[i]) begin
                bad++;
                $display("FAIL call16_c%0d ctl=%b done=%b adr=%h dout=%h required ctl=10101 adr=%h dout=%h", i, {m_we, m_re, m_sp_en, m_dir, m_busy}, m_done, m_adr, m_dout, ea[i], ed[i]);
            end
            step();
        end
        total++;
        if (m_busy !== 1'b0 || sp_m !== 16'h01FE) begin
            bad++;
            $display("FAIL call16_after busy=%b sp=%h required busy=0 sp=01fe", m_busy, sp_m);
        end
    endtask

    task automatic test_ret16();
        logic [15:0] ea [2];
        ea = '{16'h01FF, 16'h0200};
        sel = 1'b0;
        issue(CMD_RET, 8'h00, 22'h0);
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({m_we, m_re, m_sp_en, m_dir, m_busy, m_done} !== 6'b011110 || m_adr !== ea[i]) begin
                bad++;
                $display("FAIL ret16_rd%0d ctl=%b adr=%h required ctl=011110 adr=%h", i, {m_we, m_re, m_sp_en, m_dir, m_busy, m_done}, m_adr, ea[i]);
            end
            step();
        end
        total++;
        if ({m_we, m_re, m_sp_en, m_busy, m_done} !== 5'b00011 || m_ret !== 22'h0) begin
            bad++;
            $display("FAIL ret16_cap ctl=%b ret_pc=%h required ctl=00011 ret_pc=0", {m_we, m_re, m_sp_en, m_busy, m_done}, m_ret);
        end
        step();
        total++;
        if (m_ret !== 22'h001234 || sp_m !== 16'h0200 || m_busy !== 1'b0) begin
            bad++;
            $display("FAIL ret16_result ret_pc=%h sp=%h busy=%b required 001234/0200/0", m_ret, sp_m, m_busy);
        end
    endtask

    task automatic test_pc22();
        logic [15:0] wa [3];
        logic [7:0]  wd [3];
        logic [15:0] ra [3];
        wa = '{16'h0300, 16'h02FF, 16'h02FE};
        wd = '{8'hDE, 8'hBC, 8'h3A};
        ra = '{16'h02FE, 16'h02FF, 16'h0300};
        sel = 1'b1;
        set_sp(16'h0300);
        issue(CMD_CALL, 8'h00, 22'h3ABCDE);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({m_we, m_re, m_sp_en, m_dir, m_busy} !== 5'b10101 || m_done !== (i == 2) || m_adr !== wa[i] || m_dout !== wd[i]) begin
                bad++;
                $display("FAIL call22_c%0d ctl=%b done=%b adr=%h dout=%h required adr=%h dout=%h", i, {m_we, m_re, m_sp_en, m_dir, m_busy}, m_done, m_adr, m_dout, wa[i], wd[i]);
            end
            step();
        end
        total++;
        if (sp_m !== 16'h02FD) begin
            bad++;
            $display("FAIL call22_sp sp=%h required=02fd", sp_m);
        end
        // Garbage in bits 7:6 of the top byte must be dropped
        set_mem(16'h02FE, 8'hFA);
        issue(CMD_RET, 8'h00, 22'h0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({m_we, m_re, m_sp_en, m_dir, m_busy, m_done} !== 6'b011110 || m_adr !== ra[i]) begin
                bad++;
                $display("FAIL ret22_rd%0d ctl=%b adr=%h required ctl=011110 adr=%h", i, {m_we, m_re, m_sp_en, m_dir, m_busy, m_done}, m_adr, ra[i]);
            end
            step();
        end
        total++;
        if ({m_we, m_re, m_sp_en, m_busy, m_done} !== 5'b00011) begin
            bad++;
            $display("FAIL ret22_cap ctl=%b required=00011", {m_we, m_re, m_sp_en, m_busy, m_done});
        end
        step();
        total++;
        if (m_ret !== 22'h3ABCDE || sp_m !== 16'h0300) begin
            bad++;
            $display("FAIL ret22_result ret_pc=%h sp=%h required 3abcde/0300", m_ret, sp_m);
        end
    endtask

    task automatic test_pop_wrap();
        sel = 1'b0;
        set_sp(16'hFFFF);
        set_mem(16'h0000, 8'h5A);
        issue(CMD_POP, 8'h00, 22'h0);
        total++;
        if ({m_we, m_re, m_sp_en, m_dir, m_busy, m_done} !== 6'b011110 || m_adr !== 16'h0000) begin
            bad++;
            $display("FAIL pop_rd ctl=%b adr=%h required ctl=011110 adr=0000", {m_we, m_re, m_sp_en, m_dir, m_busy, m_done}, m_adr);
        end
        step();
        total++;
        if ({m_we, m_re, m_sp_en, m_busy, m_done} !== 5'b00011 || m_pop !== 8'h00) begin
            bad++;
            $display("FAIL pop_cap ctl=%b pop=%h required ctl=00011 pop=00", {m_we, m_re, m_sp_en, m_busy, m_done}, m_pop);
        end
        step();
        total++;
        if (m_pop !== 8'h5A || sp_m !== 16'h0000 || m_busy !== 1'b0) begin
            bad++;
            $display("FAIL pop_result pop=%h sp=%h busy=%b required 5a/0000/0", m_pop, sp_m, m_busy);
        end
    endtask

    task automatic test_stall();
        sel = 1'b0;
        set_sp(16'h0400);
        issue(CMD_CALL, 8'h00, 22'h00BEEF);
        total++;
        if (m_we !== 1'b1 || m_adr !== 16'h0400 || m_dout !== 8'hEF) begin
            bad++;
            $display("FAIL stall_c0 we=%b adr=%h dout=%h required 1/0400/ef", m_we, m_adr, m_dout);
        end
        cp2en = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({m_we, m_re, m_sp_en, m_done, m_busy} !== 5'b00001 || sp_m !== 16'h0400) begin
                bad++;
                $display("FAIL stall_hold%0d ctl=%b sp=%h required ctl=00001 sp=0400", i, {m_we, m_re, m_sp_en, m_done, m_busy}, sp_m);
            end
            step();
        end
        cp2en = 1'b1;
        #1;
        total++;
        if (m_we !== 1'b1 || m_adr !== 16'h0400 || m_dout !== 8'hEF || m_done !== 1'b0) begin
            bad++;
            $display("FAIL stall_resume0 we=%b adr=%h dout=%h done=%b required 1/0400/ef/0", m_we, m_adr, m_dout, m_done);
        end
        step();
        total++;
        if (m_we !== 1'b1 || m_adr !== 16'h03FF || m_dout !== 8'hBE || m_done !== 1'b1) begin
            bad++;
            $display("FAIL stall_resume1 we=%b adr=%h dout=%h done=%b required 1/03ff/be/1", m_we, m_adr, m_dout, m_done);
        end
        step();
        total++;
        if (m_busy !== 1'b0 || sp_m !== 16'h03FE) begin
            bad++;
            $display("FAIL stall_after busy=%b sp=%h required 0/03fe", m_busy, sp_m);
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        set_sp(16'h0500);
        cmd_valid = 1'b1; cmd = CMD_CALL; pc_in = 22'h00CAFE;
        step();
        // Held request while busy must be ignored until the done cycle
        cmd = CMD_PUSH; push_data = 8'h99;
        #1;
        total++;
        if (m_we !== 1'b1 || m_adr !== 16'h0500 || m_dout !== 8'hFE || m_done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_c0 we=%b adr=%h dout=%h done=%b required 1/0500/fe/0", m_we, m_adr, m_dout, m_done);
        end
        step();
        total++;
        if (m_we !== 1'b1 || m_adr !== 16'h04FF || m_dout !== 8'hCA || m_done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_c1 we=%b adr=%h dout=%h done=%b required 1/04ff/ca/1", m_we, m_adr, m_dout, m_done);
        end
        step();
        cmd_valid = 1'b0; push_data = 8'h00;
        #1;
        total++;
        if (m_we !== 1'b1 || m_adr !== 16'h04FE || m_dout !== 8'h99 || m_done !== 1'b1 || m_busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_push we=%b adr=%h dout=%h done=%b busy=%b required 1/04fe/99/1/1", m_we, m_adr, m_dout, m_done, m_busy);
        end
        step();
        total++;
        if (m_busy !== 1'b0 || sp_m !== 16'h04FD || mem[16'h04FE] !== 8'h99) begin
            bad++;
            $display("FAIL b2b_after busy=%b sp=%h mem=%h required 0/04fd/99", m_busy, sp_m, mem[16'h04FE]);
        end
    endtask

    task automatic test_reset_mid_ret();
        sel = 1'b1;
        set_sp(16'h02FD);
        issue(CMD_RET, 8'h00, 22'h0);
        total++;
        if (m_re !== 1'b1 || m_adr !== 16'h02FE) begin
            bad++;
            $display("FAIL abort_rd0 re=%b adr=%h required 1/02fe", m_re, m_adr);
        end
        step();
        ireset = 1'b0;
        #1;
        total++;
        if ({busy1, done1, sp_en1, dir1, we1, re1, adr1, dout1, pop1, ret1} !== 60'h0) begin
            bad++;
            $display("FAIL abort_outputs outputs=%h required=0", {busy1, done1, sp_en1, dir1, we1, re1, adr1, dout1, pop1, ret1});
        end
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (m_done !== 1'b0 || m_busy !== 1'b0) begin
                bad++;
                $display("FAIL abort_nodone%0d done=%b busy=%b required 0/0", i, m_done, m_busy);
            end
        end
        ireset = 1'b1;
        set_sp(16'h0600);
        issue(CMD_PUSH, 8'h5C, 22'h0);
        total++;
        if (m_we !== 1'b1 || m_adr !== 16'h0600 || m_dout !== 8'h5C || m_done !== 1'b1) begin
            bad++;
            $display("FAIL abort_next we=%b adr=%h dout=%h done=%b required 1/0600/5c/1", m_we, m_adr, m_dout, m_done);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_push();
        test_call16();
        test_ret16();
        test_pc22();
        test_pop_wrap();
        test_stall();
        test_back_to_back();
        test_reset_mid_ret();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
